// File: rtl/sift_orient_pkg.sv
// Shared constants and scan-state encoding for the orientation peak finder.
package sift_orient_pkg;
    localparam int NBINS   = 36;
    localparam int BIN_W   = 16;
    localparam int IDX_W   = 6;
    localparam int THR_NUM = 4;
    localparam int THR_DEN = 5;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MAX_SCAN  = 2'd1,
        PEAK_SCAN = 2'd2,
        DONE      = 2'd3
    } state_e;
endpackage

// File: rtl/orient_peak_compare.sv
// Qualifies one histogram bin as a reportable circular local maximum.
module orient_peak_compare #(
    parameter int BIN_W   = sift_orient_pkg::BIN_W,
    parameter int THR_NUM = sift_orient_pkg::THR_NUM,
    parameter int THR_DEN = sift_orient_pkg::THR_DEN
) (
    input  logic [BIN_W-1:0] center,
    input  logic [BIN_W-1:0] left,
    input  logic [BIN_W-1:0] right,
    input  logic [BIN_W-1:0] max_val,
    output logic             is_peak
);
    // Headroom for the ratio multiply so neither side ever truncates.
    localparam int PROD_W = BIN_W + 8;

    logic [PROD_W-1:0] center_scaled;
    logic [PROD_W-1:0] max_scaled;

    assign center_scaled = PROD_W'(center)  * PROD_W'(THR_DEN);
    assign max_scaled    = PROD_W'(max_val) * PROD_W'(THR_NUM);

    // Strict on the left, inclusive on the right: a flat plateau reports its left bin only.
    assign is_peak = (center > left) && (center >= right) && (max_val != '0)
                     && (center_scaled >= max_scaled);
endmodule

// File: rtl/dominant_orientation_peak_finder.sv
// Scans a 36-bin orientation histogram: global max pass, then a circular peak pass
// reporting every local maximum within the threshold ratio of the max.
module dominant_orientation_peak_finder #(
    parameter int BIN_W   = sift_orient_pkg::BIN_W,
    parameter int NBINS   = sift_orient_pkg::NBINS,
    parameter int THR_NUM = sift_orient_pkg::THR_NUM,
    parameter int THR_DEN = sift_orient_pkg::THR_DEN
) (
    input  logic             iclk,
    input  logic             ireset,
    input  logic             idata_en,
    input  logic [BIN_W-1:0] istatistics_orientation0,
    input  logic [BIN_W-1:0] istatistics_orientation1,
    input  logic [BIN_W-1:0] istatistics_orientation2,
    input  logic [BIN_W-1:0] istatistics_orientation3,
    input  logic [BIN_W-1:0] istatistics_orientation4,
    input  logic [BIN_W-1:0] istatistics_orientation5,
    input  logic [BIN_W-1:0] istatistics_orientation6,
    input  logic [BIN_W-1:0] istatistics_orientation7,
    input  logic [BIN_W-1:0] istatistics_orientation8,
    input  logic [BIN_W-1:0] istatistics_orientation9,
    input  logic [BIN_W-1:0] istatistics_orientation10,
    input  logic [BIN_W-1:0] istatistics_orientation11,
    input  logic [BIN_W-1:0] istatistics_orientation12,
    input  logic [BIN_W-1:0] istatistics_orientation13,
    input  logic [BIN_W-1:0] istatistics_orientation14,
    input  logic [BIN_W-1:0] istatistics_orientation15,
    input  logic [BIN_W-1:0] istatistics_orientation16,
    input  logic [BIN_W-1:0] istatistics_orientation17,
    input  logic [BIN_W-1:0] istatistics_orientation18,
    input  logic [BIN_W-1:0] istatistics_orientation19,
    input  logic [BIN_W-1:0] istatistics_orientation20,
    input  logic [BIN_W-1:0] istatistics_orientation21,
    input  logic [BIN_W-1:0] istatistics_orientation22,
    input  logic [BIN_W-1:0] istatistics_orientation23,
    input  logic [BIN_W-1:0] istatistics_orientation24,
    input  logic [BIN_W-1:0] istatistics_orientation25,
    input  logic [BIN_W-1:0] istatistics_orientation26,
    input  logic [BIN_W-1:0] istatistics_orientation27,
    input  logic [BIN_W-1:0] istatistics_orientation28,
    input  logic [BIN_W-1:0] istatistics_orientation29,
    input  logic [BIN_W-1:0] istatistics_orientation30,
    input  logic [BIN_W-1:0] istatistics_orientation31,
    input  logic [BIN_W-1:0] istatistics_orientation32,
    input  logic [BIN_W-1:0] istatistics_orientation33,
    input  logic [BIN_W-1:0] istatistics_orientation34,
    input  logic [BIN_W-1:0] istatistics_orientation35,
    output logic             obusy,
    output logic             opeak_valid,
    output logic [5:0]       opeak_bin,
    output logic [BIN_W-1:0] opeak_mag,
    output logic             opeak_primary,
    output logic             odone,
    output logic             odropped
);
    import sift_orient_pkg::*;

    localparam int             IW       = IDX_W;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBINS - 1);

    logic [BIN_W-1:0] in_bins [NBINS];
    assign in_bins[0]  = istatistics_orientation0;
    assign in_bins[1]  = istatistics_orientation1;
    assign in_bins[2]  = istatistics_orientation2;
    assign in_bins[3]  = istatistics_orientation3;
    assign in_bins[4]  = istatistics_orientation4;
    assign in_bins[5]  = istatistics_orientation5;
    assign in_bins[6]  = istatistics_orientation6;
    assign in_bins[7]  = istatistics_orientation7;
    assign in_bins[8]  = istatistics_orientation8;
    assign in_bins[9]  = istatistics_orientation9;
    assign in_bins[10] = istatistics_orientation10;
    assign in_bins[11] = istatistics_orientation11;
    assign in_bins[12] = istatistics_orientation12;
    assign in_bins[13] = istatistics_orientation13;
    assign in_bins[14] = istatistics_orientation14;
    assign in_bins[15] = istatistics_orientation15;
    assign in_bins[16] = istatistics_orientation16;
    assign in_bins[17] = istatistics_orientation17;
    assign in_bins[18] = istatistics_orientation18;
    assign in_bins[19] = istatistics_orientation19;
    assign in_bins[20] = istatistics_orientation20;
    assign in_bins[21] = istatistics_orientation21;
    assign in_bins[22] = istatistics_orientation22;
    assign in_bins[23] = istatistics_orientation23;
    assign in_bins[24] = istatistics_orientation24;
    assign in_bins[25] = istatistics_orientation25;
    assign in_bins[26] = istatistics_orientation26;
    assign in_bins[27] = istatistics_orientation27;
    assign in_bins[28] = istatistics_orientation28;
    assign in_bins[29] = istatistics_orientation29;
    assign in_bins[30] = istatistics_orientation30;
    assign in_bins[31] = istatistics_orientation31;
    assign in_bins[32] = istatistics_orientation32;
    assign in_bins[33] = istatistics_orientation33;
    assign in_bins[34] = istatistics_orientation34;
    assign in_bins[35] = istatistics_orientation35;

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [IW-1:0]    argmax_q, argmax_d;
    logic [BIN_W-1:0] max_q, max_d;
    logic [BIN_W-1:0] bins_q [NBINS];
    logic [BIN_W-1:0] bins_d [NBINS];
    logic             peak_valid_q, peak_valid_d;
    logic [IW-1:0]    peak_bin_q, peak_bin_d;
    logic [BIN_W-1:0] peak_mag_q, peak_mag_d;
    logic             peak_primary_q, peak_primary_d;
    logic             done_q, done_d;
    logic             dropped_q, dropped_d;

    logic [BIN_W-1:0] center, left_nb, right_nb;
    logic             is_peak;

    // Circular neighbours, wrapped explicitly at both ends.
    always_comb begin
        center   = bins_q[idx_q];
        left_nb  = (idx_q == '0)       ? bins_q[LAST_IDX] : bins_q[idx_q - IW'(1)];
        right_nb = (idx_q == LAST_IDX) ? bins_q[0]        : bins_q[idx_q + IW'(1)];
    end

    orient_peak_compare #(
        .BIN_W   (BIN_W),
        .THR_NUM (THR_NUM),
        .THR_DEN (THR_DEN)
    ) u_compare (
        .center  (center),
        .left    (left_nb),
        .right   (right_nb),
        .max_val (max_q),
        .is_peak (is_peak)
    );

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        argmax_d       = argmax_q;
        max_d          = max_q;
        bins_d         = bins_q;
        peak_valid_d   = 1'b0;
        peak_bin_d     = peak_bin_q;
        peak_mag_d     = peak_mag_q;
        peak_primary_d = 1'b0;
        done_d         = 1'b0;
        dropped_d      = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (idata_en) begin
                    bins_d   = in_bins;
                    max_d    = '0;
                    argmax_d = '0;
                    idx_d    = '0;
                    state_d  = MAX_SCAN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            MAX_SCAN: begin
                dropped_d = idata_en;
                if (center > max_q) begin
                    max_d    = center;
                    argmax_d = idx_q;
                end
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = PEAK_SCAN;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            PEAK_SCAN: begin
                dropped_d = idata_en;
                if (is_peak) begin
                    peak_valid_d   = 1'b1;
                    peak_bin_d     = idx_q;
                    peak_mag_d     = center;
                    peak_primary_d = (idx_q == argmax_q);
                end
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            argmax_q       <= '0;
            max_q          <= '0;
            peak_valid_q   <= 1'b0;
            peak_bin_q     <= '0;
            peak_mag_q     <= '0;
            peak_primary_q <= 1'b0;
            done_q         <= 1'b0;
            dropped_q      <= 1'b0;
            for (int i = 0; i < NBINS; i++) bins_q[i] <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            argmax_q       <= argmax_d;
            max_q          <= max_d;
            peak_valid_q   <= peak_valid_d;
            peak_bin_q     <= peak_bin_d;
            peak_mag_q     <= peak_mag_d;
            peak_primary_q <= peak_primary_d;
            done_q         <= done_d;
            dropped_q      <= dropped_d;
            bins_q         <= bins_d;
        end
    end

    assign obusy         = (state_q == MAX_SCAN) || (state_q == PEAK_SCAN);
    assign opeak_valid   = peak_valid_q;
    assign opeak_bin     = peak_bin_q;
    assign opeak_mag     = peak_mag_q;
    assign opeak_primary = peak_primary_q;
    assign odone         = done_q;
    assign odropped      = dropped_q;
endmodule

// File: tb/tb_dominant_orientation_peak_finder.sv
// Directed bench for the orientation peak finder with a cycle-stamped peak/done scoreboard.
module tb_dominant_orientation_peak_finder;
    logic        iclk = 1'b0;
    logic        ireset;
    logic        idata_en;
    logic [15:0] hist [36];
    logic        obusy, opeak_valid, opeak_primary, odone, odropped;
    logic [5:0]  opeak_bin;
    logic [15:0] opeak_mag;

    always #5 iclk = ~iclk;

    dominant_orientation_peak_finder dut (
        .iclk(iclk), .ireset(ireset), .idata_en(idata_en),
        .istatistics_orientation0(hist[0]),   .istatistics_orientation1(hist[1]),
        .istatistics_orientation2(hist[2]),   .istatistics_orientation3(hist[3]),
        .istatistics_orientation4(hist[4]),   .istatistics_orientation5(hist[5]),
        .istatistics_orientation6(hist[6]),   .istatistics_orientation7(hist[7]),
        .istatistics_orientation8(hist[8]),   .istatistics_orientation9(hist[9]),
        .istatistics_orientation10(hist[10]), .istatistics_orientation11(hist[11]),
        .istatistics_orientation12(hist[12]), .istatistics_orientation13(hist[13]),
        .istatistics_orientation14(hist[14]), .istatistics_orientation15(hist[15]),
        .istatistics_orientation16(hist[16]), .istatistics_orientation17(hist[17]),
        .istatistics_orientation18(hist[18]), .istatistics_orientation19(hist[19]),
        .istatistics_orientation20(hist[20]), .istatistics_orientation21(hist[21]),
        .istatistics_orientation22(hist[22]), .istatistics_orientation23(hist[23]),
        .istatistics_orientation24(hist[24]), .istatistics_orientation25(hist[25]),
        .istatistics_orientation26(hist[26]), .istatistics_orientation27(hist[27]),
        .istatistics_orientation28(hist[28]), .istatistics_orientation29(hist[29]),
        .istatistics_orientation30(hist[30]), .istatistics_orientation31(hist[31]),
        .istatistics_orientation32(hist[32]), .istatistics_orientation33(hist[33]),
        .istatistics_orientation34(hist[34]), .istatistics_orientation35(hist[35]),
        .obusy(obusy), .opeak_valid(opeak_valid), .opeak_bin(opeak_bin),
        .opeak_mag(opeak_mag), .opeak_primary(opeak_primary),
        .odone(odone), .odropped(odropped)
    );

    int cyc = 0;
    always @(posedge iclk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int   bin;
        int   mag;
        logic prim;
        int   at;
    } rec_t;
    rec_t rec_q[$];
    int   done_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic launch(output int e0);
        @(negedge iclk);
        idata_en = 1'b1;
        e0 = cyc + 1;
        @(posedge iclk);
        #1 idata_en = 1'b0;
        $display("[TB] histogram accepted at cycle %0d", e0);
    endtask

    task automatic wait_cyc(input int n);
        @(negedge iclk);
        while (cyc < n) @(negedge iclk);
    endtask

    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < 36; i++) hist[i] = v;
    endtask

    task automatic expect_peak(input int e0, input int b, input int m, input logic p);
        rec_t r;
        r.bin = b; r.mag = m; r.prim = p; r.at = e0 + 37 + b;
        rec_q.push_back(r);
    endtask

    task automatic expect_done(input int e0);
        done_q.push_back(e0 + 72);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},    32'(obusy),         0);
        chk({tag, "_valid"},   32'(opeak_valid),   0);
        chk({tag, "_bin"},     32'(opeak_bin),     0);
        chk({tag, "_mag"},     32'(opeak_mag),     0);
        chk({tag, "_primary"}, 32'(opeak_primary), 0);
        chk({tag, "_done"},    32'(odone),         0);
        chk({tag, "_dropped"}, 32'(odropped),      0);
    endtask

    // Scoreboard: every peak record and done strobe must match the queue head, on time.
    always @(negedge iclk) begin
        if (opeak_valid === 1'b1) begin
            if (rec_q.size() == 0) begin
                chk("spurious_peak_bin", 32'(opeak_bin), 32'hFFFF_FFFF);
            end else begin
                rec_t r;
                r = rec_q.pop_front();
                $display("[TB] peak bin=%0d mag=%0d primary=%0d cycle=%0d", opeak_bin, opeak_mag, opeak_primary, cyc);
                chk("peak_bin",     32'(opeak_bin),     32'(r.bin));
                chk("peak_mag",     32'(opeak_mag),     32'(r.mag));
                chk("peak_primary", 32'(opeak_primary), 32'(r.prim));
                chk("peak_cycle",   32'(cyc),           32'(r.at));
            end
        end
        if (odone === 1'b1) begin
            if (done_q.size() == 0) begin
                chk("spurious_done_cycle", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                int at;
                at = done_q.pop_front();
                $display("[TB] done cycle=%0d", cyc);
                chk("done_cycle", 32'(cyc), 32'(at));
            end
        end
    end

    initial begin
        int e0, e1;
        ireset   = 1'b0;
        idata_en = 1'b0;
        fill(16'd0);
        repeat (3) @(negedge iclk);
        chk_all_zero("reset");
        ireset = 1'b1;

        // Single dominant peak
        fill(16'd100); hist[10] = 16'd1000;
        launch(e0);
        expect_peak(e0, 10, 1000, 1'b1); expect_done(e0);
        wait_cyc(e0);
        chk("busy_after_accept", 32'(obusy), 1);
        wait_cyc(e0 + 48);
        chk("hold_valid", 32'(opeak_valid), 0);
        chk("hold_bin",   32'(opeak_bin),   10);
        chk("hold_mag",   32'(opeak_mag),   1000);
        wait_cyc(e0 + 71);
        chk("busy_last_peak_cycle", 32'(obusy), 1);
        wait_cyc(e0 + 72);
        chk("busy_in_done", 32'(obusy), 0);
        wait_cyc(e0 + 74);

        // Secondary peak at exactly 80 %, and one just below
        fill(16'd10); hist[5] = 16'd1000; hist[20] = 16'd800; hist[30] = 16'd799;
        launch(e0);
        expect_peak(e0, 5, 1000, 1'b1); expect_peak(e0, 20, 800, 1'b0); expect_done(e0);
        wait_cyc(e0 + 74);

        // Wrap-around: bin 0 beats both circular neighbours
        fill(16'd0); hist[0] = 16'd500; hist[35] = 16'd400; hist[1] = 16'd300;
        launch(e0);
        expect_peak(e0, 0, 500, 1'b1); expect_done(e0);
        wait_cyc(e0 + 74);

        // Wrap-around: bin 35 wins, record coincides with done
        hist[35] = 16'd600;
        launch(e0);
        expect_peak(e0, 35, 600, 1'b1); expect_done(e0);
        wait_cyc(e0 + 74);

        // Two-bin plateau: left bin only, and it is the argmax
        fill(16'd0); hist[7] = 16'd900; hist[8] = 16'd900;
        launch(e0);
        expect_peak(e0, 7, 900, 1'b1); expect_done(e0);
        wait_cyc(e0 + 74);

        // All-zero histogram
        fill(16'd0);
        launch(e0);
        expect_done(e0);
        wait_cyc(e0 + 74);

        // Overlap: drop at E20, back-to-back accept at E73
        fill(16'd100); hist[10] = 16'd1000;
        launch(e0);
        expect_peak(e0, 10, 1000, 1'b1); expect_done(e0);
        wait_cyc(e0 + 19);
        fill(16'd3); hist[2] = 16'd5000;
        idata_en = 1'b1;
        @(posedge iclk);
        #1 idata_en = 1'b0;
        @(negedge iclk);
        chk("dropped_pulse", 32'(odropped), 1);
        chk("busy_during_drop", 32'(obusy), 1);
        @(negedge iclk);
        chk("dropped_one_cycle", 32'(odropped), 0);
        fill(16'd10); hist[5] = 16'd1000; hist[20] = 16'd800; hist[30] = 16'd799;
        wait_cyc(e0 + 71);
        launch(e1);
        chk("b2b_accept_cycle", 32'(e1 - e0), 73);
        expect_peak(e1, 5, 1000, 1'b1); expect_peak(e1, 20, 800, 1'b0); expect_done(e1);
        wait_cyc(e1);
        chk("b2b_busy", 32'(obusy), 1);
        wait_cyc(e1 + 74);

        // Reset mid PEAK_SCAN, before the bin-10 record would appear
        fill(16'd100); hist[10] = 16'd1000;
        launch(e0);
        wait_cyc(e0 + 40);
        ireset = 1'b0;
        #1;
        chk_all_zero("midscan_reset");
        repeat (2) @(negedge iclk);
        ireset = 1'b1;
        wait_cyc(e0 + 80);
        chk("post_reset_idle_busy", 32'(obusy), 0);

        fill(16'd0); hist[7] = 16'd900; hist[8] = 16'd900;
        launch(e0);
        expect_peak(e0, 7, 900, 1'b1); expect_done(e0);
        wait_cyc(e0 + 74);

        chk("peaks_outstanding", 32'(rec_q.size()), 0);
        chk("dones_outstanding", 32'(done_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
